alu_operand_loader: RTL

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/alu_operand_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - captures A, B and opcode nibbles from a slow load strobe, then latches the ALU result
// Define ALU_LOADER_ACC_EN to chain the previous result's low nibble into operand A.
module alu_operand_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       load,
  input  logic [7:0] alu_result,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] opcode,
  output logic [7:0] result,
  output logic       result_valid,
  output logic [2:0] state,
  output logic [7:0] op_count
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    HOLD    = 3'd4
  } state_e;

  logic [2:0] state_q;
  logic [3:0] op_a_q;
  logic [3:0] op_b_q;
  logic [3:0] opcode_q;
  logic [7:0] result_q;
  logic       result_valid_q;
  logic [7:0] op_count_q;
  logic       load_s1_q;
  logic       load_s2_q;
  logic       load_prev_q;
  logic [1:0] warm_q;
  logic       armed_q;
  logic       load_evt;

  // armed_q stays low until the synchronised strobe has been seen low once,
  // so a strobe already high when reset releases never counts as an edge.
  assign load_evt = load_s2_q & ~load_prev_q & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LOAD_A;
      op_a_q         <= 4'h0;
      op_b_q         <= 4'h0;
      opcode_q       <= 4'h0;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      op_count_q     <= 8'h00;
      load_s1_q      <= 1'b0;
      load_s2_q      <= 1'b0;
      load_prev_q    <= 1'b0;
      warm_q         <= 2'd0;
      armed_q        <= 1'b0;
    end else begin
      load_s1_q   <= load;
      load_s2_q   <= load_s1_q;
      load_prev_q <= load_s2_q;
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
      if (warm_q == 2'd2 && !load_s2_q) armed_q <= 1'b1;

      case (state_q)
        LOAD_A: begin
          if (load_evt) begin
            op_a_q  <= data_in;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (load_evt) begin
            op_b_q  <= data_in;
            state_q <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (load_evt) begin
            opcode_q <= data_in;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          result_q       <= alu_result;
          result_valid_q <= 1'b1;
          op_count_q     <= op_count_q + 8'h01;
          state_q        <= HOLD;
        end
        HOLD: begin
          if (load_evt) begin
            result_valid_q <= 1'b0;
`ifdef ALU_LOADER_ACC_EN
            op_a_q  <= result_q[3:0];
            op_b_q  <= data_in;
            state_q <= LOAD_OP;
`else
            op_a_q  <= data_in;
            state_q <= LOAD_B;
`endif
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign opcode       = opcode_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign state        = state_q;
  assign op_count     = op_count_q;

endmodule
